// File: rtl/tqvp_uart_rx_fifo_if.sv
// tqvp_uart_rx_fifo_if: TinyQV peripheral register bus for the UART RX FIFO.
//   address    : register select (4 bits)
//   data_write : one-cycle write strobe
//   data_in    : write data, valid with data_write
//   data_out   : combinational read data
// master = CPU side, slave = peripheral side.
interface tqvp_uart_rx_fifo_if;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output address,
        output data_write,
        output data_in,
        input  data_out
    );

    modport slave (
        input  address,
        input  data_write,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/tqvp_uart_rx_fifo.sv
// tqvp_uart_rx_fifo: UART receiver (8N1) for the TinyQV peripheral bus. Received bytes are
// queued in a DEPTH-entry circular FIFO that the CPU pops explicitly.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
// Ports:
//   clk    : project clock
//   rst    : asynchronous, active-high reset
//   ui_in  : bit 7 is RX (already synchronised), bits 6:0 unused
//   uo_out : {5'b0, overrun, full, ~empty}
//   bus    : register bus (slave modport)
// Registers: 0x0 R head byte | 0x1 R level, W pop | 0x2 R status, W1C bits 3:2 |
//            0x3 R/W bit0 rx_enable, bit1 flush (self-clearing)
module tqvp_uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 556,
    parameter int unsigned DEPTH        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         ui_in,
    output logic [7:0]         uo_out,
    tqvp_uart_rx_fifo_if.slave bus
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
`ifdef UART_RX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_bad_q, par_bad_d;
    logic          rx, rx_prev_q;
    logic          push_req, frame_bad;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          rx_enable_q, overrun_q, frame_err_q;
    logic          empty, full, pop, flush, push, stat_wr, cfg_wr;

    logic unused_bits;
    assign unused_bits = ^{ui_in[6:0], bus.data_in[7:4]};

    assign rx      = ui_in[7];
    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_FULL);
    assign stat_wr = bus.data_write && (bus.address == 4'h2);
    assign cfg_wr  = bus.data_write && (bus.address == 4'h3);
    assign pop     = bus.data_write && (bus.address == 4'h1) && !empty;
    assign flush   = cfg_wr && bus.data_in[1];
    // A full FIFO drops the byte; flush discards a concurrent push.
    assign push    = push_req && !flush && !full;

    // ---------------- RX state machine ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_bad_q <= par_bad_d;
            rx_prev_q <= rx;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_bad_d = par_bad_q;
        push_req  = 1'b0;
        frame_bad = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_prev_q && !rx) begin
                    state_d   = StStart;
                    cnt_d     = '0;
                    par_bad_d = 1'b0;
                end
            end
            StStart: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx ? StIdle : StData;  // high at mid-start is a glitch
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx, shreg_q[7:1]};  // LSB arrives first
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = PARITY_EN ? StParity : StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = rx ^ (^shreg_q);  // even parity over data + parity bit
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                // Sampled mid-bit, so the FSM idles for the stop bit's second half.
                if (cnt_q == BIT_LAST) begin
                    state_d = StIdle;
                    if (rx && !par_bad_q) push_req  = 1'b1;
                    else                  frame_bad = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!rx_enable_q) begin
            state_d   = StIdle;
            push_req  = 1'b0;
            frame_bad = 1'b0;
        end
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= shreg_q;
    end

    // ---------------- Control / sticky flags ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_enable_q <= 1'b1;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // Clear-then-set so a new error in the clear cycle survives.
            overrun_q   <= (overrun_q && !(stat_wr && bus.data_in[2]))
                           || (push_req && full && !flush);
            frame_err_q <= (frame_err_q && !(stat_wr && bus.data_in[3])) || frame_bad;
            if (cfg_wr) rx_enable_q <= bus.data_in[0];
        end
    end

    // ---------------- Read mux ----------------
    always_comb begin
        bus.data_out = 8'h00;
        unique case (bus.address)
            4'h0:    if (!empty) bus.data_out = mem[rd_ptr_q];
            4'h1:    bus.data_out = 8'(level_q);
            4'h2:    bus.data_out = {3'b000, PARITY_EN, frame_err_q, overrun_q, full, empty};
            4'h3:    bus.data_out = {7'b0, rx_enable_q};
            default: bus.data_out = 8'h00;
        endcase
    end

    assign uo_out = {5'b0, overrun_q, full, !empty};
endmodule
